// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage: owns the PC, drives a synchronous instruction memory, buffers
// returned words together with their PCs, and hands them to decode over a
// valid/ready handshake. A downstream redirect flushes the buffer and restarts
// fetch at the (word-aligned) target.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   imem_req        memory read strobe (an issue this cycle)
//   imem_addr       read address, always the current PC
//   imem_rdata      read data, valid the cycle after imem_req
//   redirect_valid  branch taken / jump from downstream
//   redirect_pc     redirect target (low two bits ignored)
//   if_valid        buffer head holds an instruction
//   if_instr        instruction at buffer head (0 when empty)
//   if_pc           PC of if_instr (0 when empty)
//   id_ready        decode accepts the head this cycle
//   perf_fetch_cnt  (IF_PERF_CNT_EN only) saturating count of issue cycles
//   perf_flush_cnt  (IF_PERF_CNT_EN only) saturating count of redirects that
//                   discard buffered or in-flight work
//
// Build option: define IF_PERF_CNT_EN to add the two performance counters.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH   = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    input  logic                id_ready
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pend_pc;
    logic                r_inflight;
    logic [CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [31:0]         r_fifo_instr [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];

    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [CNT_W:0]      w_occ;
    logic [PC_WIDTH-1:0] w_target;

    // ---- issue / handshake decode ------------------------------------------
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && id_ready;
    // A response arriving alongside a redirect belongs to the old path.
    assign w_push   = r_inflight && !redirect_valid;
    assign w_target = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    // Occupancy counts the in-flight response as already holding a slot, so
    // the buffer can never be overrun. A pop implies count >= 1, so no wrap.
    assign w_occ   = {1'b0, r_count}
                   + {{CNT_W{1'b0}}, r_inflight}
                   - {{CNT_W{1'b0}}, w_pop};
    assign w_issue = !rst && !redirect_valid && (w_occ < (CNT_W+1)'(FIFO_DEPTH));

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    assign if_valid = w_valid;
    assign if_instr = w_valid ? r_fifo_instr[r_rd_ptr] : 32'd0;
    assign if_pc    = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;

    // ---- control state: PC, in-flight flag, buffer pointers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_target;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_pc     <= r_pc + PC_WIDTH'(4);
            if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---- data path: pending PC and buffer storage (no reset needed) --------
    always_ff @(posedge clk) begin
        if (w_issue) r_pend_pc <= r_pc;
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_pend_pc;
        end
    end

    // A push into a full buffer without a matching pop would lose data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));
        end
    end

`ifdef IF_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;

    // ---- performance counters ----------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            if (w_issue) r_perf_fetch <= sat_inc(r_perf_fetch);
            if (redirect_valid && (w_valid || r_inflight))
                r_perf_flush <= sat_inc(r_perf_flush);
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready = 1'b0;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_unit #(
        .PC_WIDTH  (64),
        .RESET_PC  (64'h0),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memory: word at addr is addr+0x13; garbage when not read.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr[31:0] + 32'h13;
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else n_pass++;
        n_checks++; if (if_instr !== 32'd0) $display("FAIL reset_instr: got %h want 0", if_instr); else n_pass++;
        n_checks++; if (if_pc !== 64'd0) $display("FAIL reset_pc: got %h want 0", if_pc); else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_checks++; if (perf_fetch_cnt !== 32'd0) $display("FAIL reset_perf_fetch: got %0d want 0", perf_fetch_cnt); else n_pass++;
        n_checks++; if (perf_flush_cnt !== 32'd0) $display("FAIL reset_perf_flush: got %0d want 0", perf_flush_cnt); else n_pass++;
`endif
    endtask

    task automatic test_startup();
        logic [63:0] e;
        do_reset();
        rst = 1'b0; id_ready = 1'b1;
        #1;  // cycle R
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'd0) $display("FAIL start_fetch: got req=%b addr=%h want 1/0", imem_req, imem_addr); else n_pass++;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL start_valid_R: got %b want 0", if_valid); else n_pass++;
        tick();  // R+1
        n_checks++; if (if_valid !== 1'b0 || imem_addr !== 64'd4) $display("FAIL start_R1: got valid=%b addr=%h want 0/4", if_valid, imem_addr); else n_pass++;
        tick();  // R+2
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'd0 || if_instr !== 32'h13) $display("FAIL start_first: got v=%b pc=%h ins=%h want 1/0/13", if_valid, if_pc, if_instr); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            e = 64'(4 * k);
            n_checks++; if (if_valid !== 1'b1 || if_pc !== e || if_instr !== e[31:0] + 32'h13) $display("FAIL stream_%0d: got v=%b pc=%h ins=%h want pc=%h", k, if_valid, if_pc, if_instr, e); else n_pass++;
        end
`ifdef IF_PERF_CNT_EN
        n_checks++; if (perf_fetch_cnt !== 32'd5) $display("FAIL perf_fetch: got %0d want 5", perf_fetch_cnt); else n_pass++;
`endif
    endtask

    task automatic test_stall();
        do_reset();
        rst = 1'b0; id_ready = 1'b1;
        #1;
        tick();
        tick();  // R+2, first valid: hold off decode
        id_ready = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'd0) $display("FAIL stall_first: got v=%b pc=%h want 1/0", if_valid, if_pc); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (imem_req !== 1'b0 || imem_addr !== 64'd8 || if_valid !== 1'b1 || if_pc !== 64'd0) $display("FAIL stall_hold_%0d: got req=%b addr=%h v=%b pc=%h want 0/8/1/0", k, imem_req, imem_addr, if_valid, if_pc); else n_pass++;
        end
        tick();
        id_ready = 1'b1;
        #1;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'd0 || imem_req !== 1'b1) $display("FAIL release_0: got v=%b pc=%h req=%b want 1/0/1", if_valid, if_pc, imem_req); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'd4 || if_instr !== 32'h17) $display("FAIL release_4: got v=%b pc=%h ins=%h want 1/4/17", if_valid, if_pc, if_instr); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'd8 || if_instr !== 32'h1B) $display("FAIL release_8: got v=%b pc=%h ins=%h want 1/8/1b", if_valid, if_pc, if_instr); else n_pass++;
    endtask

    task automatic test_redirect(input logic [63:0] tgt, input logic [63:0] al);
        do_reset();
        rst = 1'b0; id_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) tick();  // buffer now holds pcs 0 and 4
        redirect_valid = 1'b1; redirect_pc = tgt;
        #1;  // cycle N
        n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 64'd0) $display("FAIL redir_N_%h: got req=%b v=%b pc=%h want 0/1/0", tgt, imem_req, if_valid, if_pc); else n_pass++;
        tick();
        redirect_valid = 1'b0;
        #1;  // N+1
        n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== al) $display("FAIL redir_N1_%h: got v=%b req=%b addr=%h want 0/1/%h", tgt, if_valid, imem_req, imem_addr, al); else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_checks++; if (perf_flush_cnt !== 32'd1) $display("FAIL perf_flush: got %0d want 1", perf_flush_cnt); else n_pass++;
`endif
        tick();  // N+2
        n_checks++; if (if_valid !== 1'b0 || imem_addr !== al + 64'd4) $display("FAIL redir_N2_%h: got v=%b addr=%h want 0/%h", tgt, if_valid, imem_addr, al + 64'd4); else n_pass++;
        tick();  // N+3
        n_checks++; if (if_valid !== 1'b1 || if_pc !== al || if_instr !== al[31:0] + 32'h13) $display("FAIL redir_N3_%h: got v=%b pc=%h ins=%h want pc=%h", tgt, if_valid, if_pc, if_instr, al); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        rst = 1'b0; id_ready = 1'b1;
        #1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_top: got req=%b addr=%h want 1/fffffffffffffffc", imem_req, imem_addr); else n_pass++;
        tick();
        n_checks++; if (imem_addr !== 64'd0) $display("FAIL wrap_zero: got %h want 0", imem_addr); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_instr !== 32'h0000_000F) $display("FAIL wrap_head: got v=%b pc=%h ins=%h want 1/fffffffffffffffc/f", if_valid, if_pc, if_instr); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'd0 || if_instr !== 32'h13) $display("FAIL wrap_next: got v=%b pc=%h ins=%h want 1/0/13", if_valid, if_pc, if_instr); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        rst = 1'b0; id_ready = 1'b1;
        #1;
        tick();
        tick();  // one entry buffered
        n_checks++; if (if_valid !== 1'b1) $display("FAIL midrst_pre: got v=%b want 1", if_valid); else n_pass++;
        tick();
        rst = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL midrst_req: got %b want 0", imem_req); else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'd0) $display("FAIL midrst_restart: got v=%b req=%b addr=%h want 0/1/0", if_valid, imem_req, imem_addr); else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_checks++; if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) $display("FAIL midrst_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_flush_cnt); else n_pass++;
`endif
        tick();
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'd0) $display("FAIL midrst_first: got v=%b pc=%h want 1/0", if_valid, if_pc); else n_pass++;
    endtask

    // Decode-side scoreboard: accepted instructions must follow the program
    // order implied by sequential fetch and redirect targets.
    task automatic test_random();
        logic [63:0] exp_pc;
        int          since_redir;
        int          pops;
        do_reset();
        rst = 1'b0;
        exp_pc = 64'd0;
        since_redir = 1;
        pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            id_ready       = ($urandom_range(9) < 7);
            redirect_valid = ($urandom_range(24) == 0);
            redirect_pc    = {$urandom, $urandom};
            #1;
            if (!if_valid) begin
                n_checks++; if ({if_pc, if_instr} !== 96'd0) $display("FAIL rnd_empty_zero c%0d: got pc=%h ins=%h want 0", cyc, if_pc, if_instr); else n_pass++;
            end
            if (since_redir == 1 || since_redir == 2) begin
                n_checks++; if (if_valid !== 1'b0) $display("FAIL rnd_flush_gap c%0d: got v=%b want 0", cyc, if_valid); else n_pass++;
            end
            if (if_valid && id_ready) begin
                n_checks++; if (if_pc !== exp_pc || if_instr !== exp_pc[31:0] + 32'h13) $display("FAIL rnd_order c%0d: got pc=%h ins=%h want pc=%h", cyc, if_pc, if_instr, exp_pc); else n_pass++;
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            if (redirect_valid) begin
                n_checks++; if (imem_req !== 1'b0) $display("FAIL rnd_redir_req c%0d: got %b want 0", cyc, imem_req); else n_pass++;
                exp_pc = {redirect_pc[63:2], 2'b00};
                since_redir = 1;
            end else if (since_redir < 100) begin
                since_redir++;
            end
            tick();
        end
        redirect_valid = 1'b0;
        n_checks++; if (pops < 800) $display("FAIL rnd_progress: got %0d pops want >= 800", pops); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect(64'h100, 64'h100);
        test_redirect(64'h203, 64'h200);
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the RISC-V exercise pipeline. Owns the PC and drives the synchronous instruction memory.
- Buffers returned instruction words with their PCs in a small FIFO. Presents them to the decode stage through a valid/ready handshake.
- The decode stage passes if_instr to the register file, the control unit and the immediate extend unit.
- Branch and jump redirects from downstream flush the buffer and restart fetch at the target.

Parameters:
- PC_WIDTH, 64, width of PC and redirect target.
- RESET_PC, 64'h0, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  instruction memory read strobe.
- imem_addr  output  PC_WIDTH  read address, word aligned.
- imem_rdata  input  32  read data, valid exactly one cycle after the cycle with imem_req=1.
- redirect_valid  input  1  branch taken / jump from downstream.
- redirect_pc  input  PC_WIDTH  redirect target.
- if_valid  output  1  FIFO head holds a valid instruction.
- if_instr  output  32  instruction at FIFO head.
- if_pc  output  PC_WIDTH  PC of if_instr.
- id_ready  input  1  decode accepts head this cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - pc_q=RESET_PC, FIFO empty, inflight_q=0.
  - if_valid=0; if_instr=0 and if_pc=0 whenever the FIFO is empty.
  - imem_req=0 while rst=1.
- Pop: when if_valid && id_ready, the head is removed at the edge.
- Issue condition (combinational): imem_req = !rst && !redirect_valid && (count + inflight_q - pop) < FIFO_DEPTH.
- On issue:
  - imem_addr=pc_q.
  - pc_q <= pc_q+4, wrapping modulo 2^PC_WIDTH.
  - inflight_q <= 1.
- If no issue: inflight_q <= 0. imem_addr=pc_q regardless.
- Response: if inflight_q=1 and redirect_valid=0, {imem_rdata, pc of that fetch} is pushed at the edge. The pending PC is held in a register.
- Throughput: with id_ready held high, one instruction per cycle steady state. The FIFO never overflows, because the issue condition reserves a slot for the in-flight response.
- Latency: reset released in cycle R:
  - fetch of RESET_PC in R.
  - data pushed at end of R+1.
  - if_valid=1 in R+2.
- Redirect in cycle N (redirect_valid=1):
  - FIFO cleared.
  - The response returning in N is discarded.
  - No issue in N.
  - pc_q <= {redirect_pc[PC_WIDTH-1:2], 2'b00}; the low bits are forced to 0.
  - Fetch of the target in N+1; if_valid=1 in N+3.
  - if_valid in N reflects the pre-flush head. A pop in N is still counted by decode, but the redirect wins for all state.
- Simultaneous push and pop: both occur; count is unchanged.
- Push into a full FIFO is impossible by construction. An assertion flags it in simulation.
- id_ready=0 with a full FIFO: imem_req=0, and pc_q holds.
- Reset mid-operation: rst overrides redirect, pop and push.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds two 32-bit outputs, both reset to 0 and saturating at 32'hFFFF_FFFF:
  - perf_fetch_cnt: counts cycles with imem_req=1.
  - perf_flush_cnt: counts cycles with redirect_valid=1 while the FIFO is non-empty or a fetch is in flight.
- When undefined, the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset then id_ready=1, RESET_PC=0, memory word at addr = addr+32'h13 -> if_valid first in cycle R+2 with if_pc=0, if_instr=32'h13; then if_pc 4, 8, 12 on consecutive cycles.
- id_ready=0 for 5 cycles after first valid -> FIFO fills to 2, imem_req=0, head stays pc 0. Release -> pcs 0, 4, 8 in order, no loss and no duplicate.
- redirect_valid=1, redirect_pc=64'h100 with FIFO full -> if_valid=0 from N+1, imem_addr=64'h100 in N+1, if_pc=64'h100 in N+3.
- redirect_pc=64'h103 -> fetch at 64'h100.
- pc_q=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0.
- rst asserted for 1 cycle mid-stream with FIFO at 1 entry -> if_valid=0 next cycle, fetch restarts at RESET_PC. With IF_PERF_CNT_EN defined, both counters read 0.
